// File: rtl/led_matrix_scan_pkg.sv
// ============================================================================
// Module   : led_scan_pkg
// Purpose  : Shared scan-state type and output polarity helper for the LED
//            matrix scanner.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_t;

  localparam int POL_W = 64;

  // Callers zero-extend into POL_W and truncate the result back to their width.
  function automatic logic [POL_W-1:0] apply_pol(input logic [POL_W-1:0] value,
                                                  input logic             active_low);
    return active_low ? ~value : value;
  endfunction

endpackage

`default_nettype wire

// File: rtl/led_matrix_scan_if.sv
// ============================================================================
// Module   : led_matrix_scan_if
// Purpose  : Content-side controls and pin-side drives of the LED scanner.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface led_matrix_scan_if #(
  parameter int NUM_COLS  = 4,
  parameter int ROW_WIDTH = 8,
  parameter int PWM_BITS  = 4
);

  logic                          enable;
  logic [NUM_COLS*ROW_WIDTH-1:0] frame_data;
  logic [PWM_BITS-1:0]           brightness;
  logic [ROW_WIDTH-1:0]          rows;
  logic [NUM_COLS-1:0]           cols;
  logic [$clog2(NUM_COLS)-1:0]   col_idx;
  logic                          frame_start;

  modport master (
    output enable, frame_data, brightness,
    input  rows, cols, col_idx, frame_start
  );

  modport slave (
    input  enable, frame_data, brightness,
    output rows, cols, col_idx, frame_start
  );

endinterface

`default_nettype wire

// File: rtl/led_matrix_scan_pwm.sv
// ============================================================================
// Module   : led_pwm_gen
// Purpose  : Per-column PWM counter and duty compare for the LED scanner.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_pwm_gen #(
  parameter int PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear_i,
  input  logic [PWM_BITS-1:0] bright_i,
  output logic                lit_o
);

  logic [PWM_BITS-1:0] cnt_q;
  logic [PWM_BITS-1:0] cnt_d;

  // lit_o refers to the count of the upcoming cycle, matching the registered rows.
  always_comb begin
    cnt_d = clear_i ? '0 : cnt_q + PWM_BITS'(1);
    lit_o = (cnt_d < bright_i) || (&bright_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/led_matrix_scan.sv
// ============================================================================
// Module   : led_matrix_scan
// Purpose  : Multiplexed LED-matrix column scanner with frame shadow buffer,
//            inter-column blanking and global PWM brightness.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_matrix_scan
  import led_scan_pkg::*;
#(
  parameter int NUM_COLS       = 4,
  parameter int ROW_WIDTH      = 8,
  parameter int DWELL_CYCLES   = 4096,
  parameter int BLANK_CYCLES   = 16,
  parameter int PWM_BITS       = 4,
  parameter bit ROW_ACTIVE_LOW = 1'b1,
  parameter bit COL_ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  led_matrix_scan_if.slave  bus
);

  localparam int CIW     = $clog2(NUM_COLS);
  localparam int FW      = NUM_COLS * ROW_WIDTH;
  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0]  DWELL_LOAD = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0]  BLANK_LOAD = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [CIW-1:0] LAST_COL   = CIW'(NUM_COLS - 1);

  scan_state_t          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CIW-1:0]       col_q, col_d;
  logic [FW-1:0]        shadow_q, shadow_d;
  logic [PWM_BITS-1:0]  bright_q, bright_d;
  logic                 fs_q, fs_d;
  logic [ROW_WIDTH-1:0] rows_q, rows_d;
  logic [NUM_COLS-1:0]  cols_q, cols_d;

  logic                 load;
  logic                 pwm_clear;
  logic                 lit;
  logic [ROW_WIDTH-1:0] col_bits;
  logic [ROW_WIDTH-1:0] rows_log;
  logic [NUM_COLS-1:0]  cols_log;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    col_d     = col_q;
    load      = 1'b0;
    pwm_clear = 1'b0;

    if (!bus.enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      col_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          col_d = '0;
          load  = 1'b1;
          if (BLANK_CYCLES > 0) begin
            state_d = BLANK;
            cnt_d   = BLANK_LOAD;
          end else begin
            state_d   = DRIVE;
            cnt_d     = DWELL_LOAD;
            pwm_clear = 1'b1;
          end
        end
        BLANK: begin
          if (cnt_q == '0) begin
            state_d   = DRIVE;
            cnt_d     = DWELL_LOAD;
            pwm_clear = 1'b1;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        DRIVE: begin
          if (cnt_q == '0) begin
            if (col_q == LAST_COL) begin
              col_d = '0;
              load  = 1'b1;
            end else begin
              col_d = col_q + CIW'(1);
            end
            if (BLANK_CYCLES > 0) begin
              state_d = BLANK;
              cnt_d   = BLANK_LOAD;
            end else begin
              state_d   = DRIVE;
              cnt_d     = DWELL_LOAD;
              pwm_clear = 1'b1;
            end
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          col_d   = '0;
        end
      endcase
    end
  end

  // Output image is built from next-state values so every pin is a flop.
  always_comb begin
    shadow_d = load ? bus.frame_data : shadow_q;
    bright_d = load ? bus.brightness : bright_q;
    fs_d     = load;
    col_bits = shadow_d[col_d*ROW_WIDTH +: ROW_WIDTH];
    rows_log = '0;
    cols_log = '0;
    if (state_d == DRIVE) begin
      rows_log = col_bits & {ROW_WIDTH{lit}};
      cols_log = NUM_COLS'(1) << col_d;
    end
    rows_d = ROW_WIDTH'(apply_pol(POL_W'(rows_log), ROW_ACTIVE_LOW));
    cols_d = NUM_COLS'(apply_pol(POL_W'(cols_log), COL_ACTIVE_LOW));
  end

  led_pwm_gen #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (pwm_clear),
    .bright_i (bright_d),
    .lit_o    (lit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      col_q    <= '0;
      shadow_q <= '0;
      bright_q <= '0;
      fs_q     <= 1'b0;
      rows_q   <= {ROW_WIDTH{ROW_ACTIVE_LOW}};
      cols_q   <= {NUM_COLS{COL_ACTIVE_LOW}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      col_q    <= col_d;
      shadow_q <= shadow_d;
      bright_q <= bright_d;
      fs_q     <= fs_d;
      rows_q   <= rows_d;
      cols_q   <= cols_d;
    end
  end

  assign bus.rows        = rows_q;
  assign bus.cols        = cols_q;
  assign bus.col_idx     = col_q;
  assign bus.frame_start = fs_q;

endmodule

`default_nettype wire

// File: tb/tb_led_matrix_scan.sv
// ============================================================================
// Module   : tb_led_matrix_scan
// Purpose  : Directed checks of the LED scanner with and without blanking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_matrix_scan;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rst2 = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  led_matrix_scan_if #(.NUM_COLS(4), .ROW_WIDTH(8), .PWM_BITS(2)) bus1 ();
  led_matrix_scan_if #(.NUM_COLS(4), .ROW_WIDTH(8), .PWM_BITS(2)) bus2 ();

  led_matrix_scan #(
    .NUM_COLS(4), .ROW_WIDTH(8), .DWELL_CYCLES(8), .BLANK_CYCLES(2),
    .PWM_BITS(2), .ROW_ACTIVE_LOW(1'b1), .COL_ACTIVE_LOW(1'b1)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  led_matrix_scan #(
    .NUM_COLS(4), .ROW_WIDTH(8), .DWELL_CYCLES(8), .BLANK_CYCLES(0),
    .PWM_BITS(2), .ROW_ACTIVE_LOW(1'b1), .COL_ACTIVE_LOW(1'b1)
  ) dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (bus2)
  );

  typedef struct {
    int unsigned adv;
    logic        en;
    logic [31:0] fd;
    logic [1:0]  br;
    logic [7:0]  rows;
    logic [3:0]  cols;
    logic [1:0]  idx;
    logic        fs;
  } vec_t;

  vec_t vecs [15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_fs();
    int n = 0;
    do begin
      tick();
      n++;
    end while (!bus1.frame_start && n < 100);
    chk("frame_start wait", {31'd0, bus1.frame_start}, 32'd1);
  endtask

  // Caller leaves the bench on the load cycle; column 0 drives two cycles later.
  task automatic pwm_col0(input logic [7:0] pat, input string tag);
    tick();
    tick();
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("%s rows c%0d", tag, k), {24'd0, bus1.rows}, {24'd0, (pat[k] ? 8'hFE : 8'hFF)});
      chk($sformatf("%s cols c%0d", tag, k), {28'd0, bus1.cols}, 32'hE);
      tick();
    end
  endtask

  initial begin
    // Elapsed-cycle comments count edges since enable was first sampled high.
    vecs[0]  = '{3, 1'b0, 32'h0F_F0_00_A5, 2'd3, 8'hFF, 4'hF, 2'd0, 1'b0};
    vecs[1]  = '{1, 1'b1, 32'h0F_F0_00_A5, 2'd3, 8'hFF, 4'hF, 2'd0, 1'b1}; // t1 load
    vecs[2]  = '{1, 1'b1, 32'h0F_F0_00_A5, 2'd3, 8'hFF, 4'hF, 2'd0, 1'b0}; // t2
    vecs[3]  = '{1, 1'b1, 32'h0F_F0_00_A5, 2'd3, 8'h5A, 4'hE, 2'd0, 1'b0}; // t3
    vecs[4]  = '{7, 1'b1, 32'h0F_F0_00_A5, 2'd3, 8'h5A, 4'hE, 2'd0, 1'b0}; // t10
    vecs[5]  = '{1, 1'b1, 32'h0F_F0_00_A5, 2'd3, 8'hFF, 4'hF, 2'd1, 1'b0}; // t11
    vecs[6]  = '{2, 1'b1, 32'h0F_F0_00_A5, 2'd3, 8'hFF, 4'hD, 2'd1, 1'b0}; // t13
    vecs[7]  = '{8, 1'b1, 32'h0F_F0_00_A5, 2'd3, 8'hFF, 4'hF, 2'd2, 1'b0}; // t21
    vecs[8]  = '{2, 1'b1, 32'h0F_F0_00_A5, 2'd3, 8'h0F, 4'hB, 2'd2, 1'b0}; // t23
    vecs[9]  = '{7, 1'b1, 32'hFFFF_FFFF,   2'd3, 8'h0F, 4'hB, 2'd2, 1'b0}; // t30
    vecs[10] = '{3, 1'b1, 32'hFFFF_FFFF,   2'd3, 8'hF0, 4'h7, 2'd3, 1'b0}; // t33
    vecs[11] = '{7, 1'b1, 32'hFFFF_FFFF,   2'd3, 8'hF0, 4'h7, 2'd3, 1'b0}; // t40
    vecs[12] = '{1, 1'b1, 32'hFFFF_FFFF,   2'd3, 8'hFF, 4'hF, 2'd0, 1'b1}; // t41
    vecs[13] = '{2, 1'b1, 32'hFFFF_FFFF,   2'd3, 8'h00, 4'hE, 2'd0, 1'b0}; // t43
    vecs[14] = '{10, 1'b1, 32'hFFFF_FFFF,  2'd3, 8'h00, 4'hD, 2'd1, 1'b0}; // t53

    bus1.enable = 1'b0; bus1.frame_data = '0; bus1.brightness = '0;
    bus2.enable = 1'b0; bus2.frame_data = '0; bus2.brightness = '0;

    repeat (2) tick();
    chk("reset rows", {24'd0, bus1.rows}, 32'hFF);
    chk("reset cols", {28'd0, bus1.cols}, 32'hF);
    chk("reset fs",   {31'd0, bus1.frame_start}, 32'd0);
    rst  = 1'b0;
    rst2 = 1'b0;

    for (int i = 0; i < 15; i++) begin
      bus1.enable     = vecs[i].en;
      bus1.frame_data = vecs[i].fd;
      bus1.brightness = vecs[i].br;
      repeat (vecs[i].adv) tick();
      chk($sformatf("v%0d rows", i), {24'd0, bus1.rows}, {24'd0, vecs[i].rows});
      chk($sformatf("v%0d cols", i), {28'd0, bus1.cols}, {28'd0, vecs[i].cols});
      chk($sformatf("v%0d idx",  i), {30'd0, bus1.col_idx}, {30'd0, vecs[i].idx});
      chk($sformatf("v%0d fs",   i), {31'd0, bus1.frame_start}, {31'd0, vecs[i].fs});
    end

    // Abort in DRIVE cycle 5 of column 1, then restart from column 0.
    repeat (5) tick();
    chk("abort pre cols", {28'd0, bus1.cols}, 32'hD);
    bus1.enable = 1'b0;
    tick();
    chk("abort rows", {24'd0, bus1.rows}, 32'hFF);
    chk("abort cols", {28'd0, bus1.cols}, 32'hF);
    chk("abort idx",  {30'd0, bus1.col_idx}, 32'd0);
    repeat (3) tick();
    chk("idle hold cols", {28'd0, bus1.cols}, 32'hF);
    chk("idle hold fs",   {31'd0, bus1.frame_start}, 32'd0);

    bus1.frame_data = 32'h0000_0001;
    bus1.brightness = 2'd1;
    bus1.enable     = 1'b1;
    tick();
    chk("reenable fs",   {31'd0, bus1.frame_start}, 32'd1);
    chk("reenable idx",  {30'd0, bus1.col_idx}, 32'd0);
    chk("reenable cols", {28'd0, bus1.cols}, 32'hF);
    pwm_col0(8'h11, "pwm1");

    bus1.brightness = 2'd0;
    wait_fs();
    pwm_col0(8'h00, "pwm0");

    bus1.brightness = 2'd3;
    wait_fs();
    pwm_col0(8'hFF, "pwm3");
    bus1.enable = 1'b0;

    // No blank phase: columns swap on a single edge, always exactly one active.
    bus2.frame_data = 32'h0F_F0_00_A5;
    bus2.brightness = 2'd3;
    bus2.enable     = 1'b1;
    for (int t = 1; t <= 40; t++) begin
      tick();
      chk($sformatf("nb onehot t%0d", t), $countones(~bus2.cols), 32'd1);
      if (t == 1) begin
        chk("nb t1 cols", {28'd0, bus2.cols}, 32'hE);
        chk("nb t1 rows", {24'd0, bus2.rows}, 32'h5A);
        chk("nb t1 fs",   {31'd0, bus2.frame_start}, 32'd1);
      end
      if (t == 9)  chk("nb t9 cols",  {28'd0, bus2.cols}, 32'hD);
      if (t == 17) chk("nb t17 cols", {28'd0, bus2.cols}, 32'hB);
      if (t == 25) chk("nb t25 cols", {28'd0, bus2.cols}, 32'h7);
      if (t == 33) begin
        chk("nb t33 cols", {28'd0, bus2.cols}, 32'hE);
        chk("nb t33 fs",   {31'd0, bus2.frame_start}, 32'd1);
      end
    end

    #2 rst2 = 1'b1;
    #1;
    chk("async rst cols", {28'd0, bus2.cols}, 32'hF);
    chk("async rst rows", {24'd0, bus2.rows}, 32'hFF);
    tick();
    rst2 = 1'b0;
    bus2.enable = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
